// File: rtl/capped_subtractor_pipe.sv
// Two-stage valid/ready pipeline computing the saturating signed difference a - b,
// with per-result clamp flags and a sticky count of delivered saturated results.
module capped_subtractor_pipe #(
   parameter int BITWIDTH = 32,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BITWIDTH-1:0] a,
   input  logic [BITWIDTH-1:0] b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BITWIDTH-1:0] out,
   output logic                sat_hi,
   output logic                sat_lo,
   output logic [CNT_W-1:0]    sat_count,
   input  logic                clr_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Returns {sat_hi, sat_lo, result}; the top two bits of the widened difference
   // disagree exactly when the true difference leaves the BITWIDTH signed range.
   function automatic logic [BITWIDTH+1:0] clamp_diff(input logic [BITWIDTH:0] diff);
      logic [BITWIDTH+1:0] res;
      case (diff[BITWIDTH -: 2])
         2'b01:   res = {1'b1, 1'b0, 1'b0, {(BITWIDTH-1){1'b1}}};
         2'b10:   res = {1'b0, 1'b1, 1'b1, {(BITWIDTH-1){1'b0}}};
         default: res = {1'b0, 1'b0, diff[BITWIDTH-1:0]};
      endcase
      return res;
   endfunction

   logic                s1_valid_q, s1_valid_d;
   logic [BITWIDTH-1:0] a_q, a_d, b_q, b_d;
   logic                s2_valid_q, s2_valid_d;
   logic [BITWIDTH-1:0] out_q, out_d;
   logic                sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
   logic [CNT_W-1:0]    sat_count_q, sat_count_d;

   logic                s1_adv_s, s2_adv_s;
   logic [BITWIDTH:0]   diff_s;
   logic [BITWIDTH+1:0] clamp_s;
   logic                out_hs_s;

   assign s2_adv_s = !s2_valid_q | out_ready;
   assign s1_adv_s = !s1_valid_q | s2_adv_s;
   assign diff_s   = {a_q[BITWIDTH-1], a_q} - {b_q[BITWIDTH-1], b_q};
   assign clamp_s  = clamp_diff(diff_s);
   assign out_hs_s = s2_valid_q & out_ready;

   assign in_ready  = s1_adv_s;
   assign out_valid = s2_valid_q;
   assign out       = out_q;
   assign sat_hi    = sat_hi_q;
   assign sat_lo    = sat_lo_q;
   assign sat_count = sat_count_q;

   // Operand stage: capture a/b on input handshake, otherwise hold or drain.
   always_comb begin
      s1_valid_d = s1_valid_q;
      a_d        = a_q;
      b_d        = b_q;
      if (s1_adv_s) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            a_d = a;
            b_d = b;
         end else begin
            a_d = a_q;
            b_d = b_q;
         end
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   // Result stage: load clamped difference; a bubble clears valid and flags.
   always_comb begin
      s2_valid_d = s2_valid_q;
      out_d      = out_q;
      sat_hi_d   = sat_hi_q;
      sat_lo_d   = sat_lo_q;
      if (s2_adv_s) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            sat_hi_d = clamp_s[BITWIDTH+1];
            sat_lo_d = clamp_s[BITWIDTH];
            out_d    = clamp_s[BITWIDTH-1:0];
         end else begin
            sat_hi_d = 1'b0;
            sat_lo_d = 1'b0;
         end
      end else begin
         s2_valid_d = s2_valid_q;
      end
   end

   // Saturation-event counter: clear has priority, increment sticks at max.
   always_comb begin
      sat_count_d = sat_count_q;
      if (clr_count) begin
         sat_count_d = {CNT_W{1'b0}};
      end else if (out_hs_s && (sat_hi_q || sat_lo_q) && (sat_count_q != CNT_MAX)) begin
         sat_count_d = sat_count_q + CNT_ONE;
      end else begin
         sat_count_d = sat_count_q;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         a_q         <= {BITWIDTH{1'b0}};
         b_q         <= {BITWIDTH{1'b0}};
         s2_valid_q  <= 1'b0;
         out_q       <= {BITWIDTH{1'b0}};
         sat_hi_q    <= 1'b0;
         sat_lo_q    <= 1'b0;
         sat_count_q <= {CNT_W{1'b0}};
      end else begin
         s1_valid_q  <= s1_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         s2_valid_q  <= s2_valid_d;
         out_q       <= out_d;
         sat_hi_q    <= sat_hi_d;
         sat_lo_q    <= sat_lo_d;
         sat_count_q <= sat_count_d;
      end
   end

endmodule

// File: tb/tb_capped_subtractor_pipe.sv
// Self-checking bench for capped_subtractor_pipe (BITWIDTH=32, CNT_W=4) against an
// arithmetic reference model and an expected-result queue.
module tb_capped_subtractor_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        clr_count = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        in_ready, out_valid, sat_hi, sat_lo;
   logic [31:0] out;
   logic [3:0]  sat_count;

   int n_checks = 0;
   int n_fail = 0;

   capped_subtractor_pipe #(.BITWIDTH(32), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
      .sat_hi(sat_hi), .sat_lo(sat_lo), .sat_count(sat_count), .clr_count(clr_count)
   );

   always #5 clk = ~clk;

   // Reference: {sat_hi, sat_lo, result} from exact integer subtraction and clamping.
   function automatic logic [33:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
      longint d;
      d = longint'($signed(x)) - longint'($signed(y));
      if (d > 64'sd2147483647) return {2'b10, 32'h7FFF_FFFF};
      else if (d < -64'sd2147483648) return {2'b01, 32'h8000_0000};
      else return {2'b00, d[31:0]};
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] s;
      s = $urandom_range(0, 255);
      case ($urandom_range(0, 3))
         0: return 32'h7FFF_FFFF - s;
         1: return 32'h8000_0000 + s;
         2: return $urandom;
         default: return ($urandom_range(0, 1) != 0) ? s : (32'd0 - s);
      endcase
   endfunction

   // Drive one operand pair with the output side open; return the first result seen.
   task automatic xfer(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] o, output logic h, output logic l, output int lat);
      @(posedge clk); #1;
      a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      o = out; h = sat_hi; l = sat_lo;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_in_reset_valid: got %b want 0", out_valid); end
      @(negedge clk) rst_n = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (out !== 32'd0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out); end
      n_checks++; if ({sat_hi, sat_lo} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {sat_hi, sat_lo}); end
      n_checks++; if (sat_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", sat_count); end
   endtask

   task automatic test_basic;
      logic [31:0] o; logic h, l; int lat;
      xfer(32'd5, 32'd3, o, h, l, lat);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", lat); end
      n_checks++; if (o !== 32'd2) begin n_fail++; $display("FAIL basic_5m3: got %h want 00000002", o); end
      n_checks++; if ({h, l} !== 2'b00) begin n_fail++; $display("FAIL basic_5m3_flags: got %b want 00", {h, l}); end
      xfer(32'd3, 32'd5, o, h, l, lat);
      n_checks++; if (o !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL basic_3m5: got %h want fffffffe", o); end
      n_checks++; if ({h, l} !== 2'b00) begin n_fail++; $display("FAIL basic_3m5_flags: got %b want 00", {h, l}); end
   endtask

   task automatic test_clamp;
      logic [31:0] o; logic h, l; int lat;
      @(posedge clk); #1 clr_count = 1'b1;
      @(posedge clk); #1 clr_count = 1'b0;
      xfer(32'h7FFF_FFFF, 32'hFFFF_FFFF, o, h, l, lat);
      n_checks++; if (o !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL clamp_pos: got %h want 7fffffff", o); end
      n_checks++; if ({h, l} !== 2'b10) begin n_fail++; $display("FAIL clamp_pos_flags: got %b want 10", {h, l}); end
      @(posedge clk); #1;
      n_checks++; if (sat_count !== 4'd1) begin n_fail++; $display("FAIL clamp_pos_count: got %0d want 1", sat_count); end
      xfer(32'h8000_0000, 32'd1, o, h, l, lat);
      n_checks++; if (o !== 32'h8000_0000) begin n_fail++; $display("FAIL clamp_neg: got %h want 80000000", o); end
      n_checks++; if ({h, l} !== 2'b01) begin n_fail++; $display("FAIL clamp_neg_flags: got %b want 01", {h, l}); end
      xfer(32'h8000_0000, 32'h8000_0000, o, h, l, lat);
      n_checks++; if (o !== 32'd0) begin n_fail++; $display("FAIL clamp_min_min: got %h want 0", o); end
      n_checks++; if ({h, l} !== 2'b00) begin n_fail++; $display("FAIL clamp_min_min_flags: got %b want 00", {h, l}); end
      n_checks++; if (sat_count !== 4'd2) begin n_fail++; $display("FAIL clamp_count2: got %0d want 2", sat_count); end
   endtask

   task automatic test_backpressure;
      int acc_n, del_n, first_del;
      logic acc, del;
      acc_n = 0; del_n = 0; first_del = -1;
      @(posedge clk);
      for (int cyc = 0; cyc < 40 && del_n < 6; cyc++) begin
         #1;
         in_valid = (acc_n < 6); a = acc_n; b = 32'd0; out_ready = (cyc >= 5);
         #1;
         acc = in_valid & in_ready;
         del = out_valid & out_ready;
         if (cyc >= 2 && cyc < 5) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b want 0", cyc, in_ready); end
            n_checks++; if (out_valid !== 1'b1 || out !== 32'd0) begin n_fail++; $display("FAIL bp_hold c%0d: got v=%b out=%h want v=1 out=0", cyc, out_valid, out); end
         end
         if (cyc == 5) begin
            n_checks++; if (acc_n !== 2) begin n_fail++; $display("FAIL bp_accepted: got %0d want 2", acc_n); end
         end
         if (del) begin
            if (first_del < 0) first_del = cyc;
            n_checks++; if (out !== del_n) begin n_fail++; $display("FAIL bp_order: got %h want %h", out, del_n); end
            n_checks++; if (cyc !== first_del + del_n) begin n_fail++; $display("FAIL bp_rate: item %0d at cycle %0d want %0d", del_n, cyc, first_del + del_n); end
            del_n++;
         end
         if (acc) acc_n++;
         @(posedge clk);
      end
      #1 in_valid = 1'b0; out_ready = 1'b1;
      n_checks++; if (del_n !== 6) begin n_fail++; $display("FAIL bp_delivered: got %0d want 6", del_n); end
   endtask

   task automatic test_counter;
      logic [33:0] q[$];
      logic [33:0] exp_v;
      logic [31:0] r, x, y;
      int sent, got, cnt_m;
      logic acc, del;
      sent = 0; got = 0; cnt_m = 0;
      @(posedge clk); #1 clr_count = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      for (int cyc = 0; cyc < 80 && got < 17; cyc++) begin
         #1;
         clr_count = 1'b0;
         r = $urandom_range(0, 1000);
         if ($urandom_range(0, 1) != 0) begin x = 32'h7FFF_FFFF - r; y = 32'h8000_0000 + r; end
         else begin x = 32'h8000_0000 + r; y = 32'h7FFF_FFFF - r; end
         in_valid = (sent < 17); a = x; b = y;
         #1;
         n_checks++; if (sat_count !== cnt_m[3:0]) begin n_fail++; $display("FAIL cnt_track c%0d: got %0d want %0d", cyc, sat_count, cnt_m); end
         acc = in_valid & in_ready;
         del = out_valid & out_ready;
         if (del) begin
            exp_v = (q.size() > 0) ? q.pop_front() : 34'd0;
            n_checks++; if ({sat_hi, sat_lo, out} !== exp_v) begin n_fail++; $display("FAIL cnt_result: got %h want %h", {sat_hi, sat_lo, out}, exp_v); end
            if (exp_v[33] | exp_v[32]) cnt_m = (cnt_m < 15) ? cnt_m + 1 : 15;
            got++;
         end
         if (acc) begin q.push_back(ref_sub(x, y)); sent++; end
         @(posedge clk);
      end
      #1;
      n_checks++; if (sat_count !== 4'd15) begin n_fail++; $display("FAIL cnt_sticky: got %0d want 15", sat_count); end
      in_valid = 1'b1; a = 32'h7FFF_FFFF; b = 32'h8000_0000; out_ready = 1'b0;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || sat_hi !== 1'b1 || sat_count !== 4'd15) begin n_fail++; $display("FAIL cnt_pre_clear: got v=%b hi=%b cnt=%0d want 1 1 15", out_valid, sat_hi, sat_count); end
      out_ready = 1'b1; clr_count = 1'b1;
      @(posedge clk); #1 clr_count = 1'b0;
      n_checks++; if (sat_count !== 4'd0) begin n_fail++; $display("FAIL cnt_clear_wins: got %0d want 0", sat_count); end
   endtask

   task automatic test_reset_midflight;
      logic [31:0] o; logic h, l; int lat, n_del;
      xfer(32'h7FFF_FFFF, 32'hFFFF_FFFF, o, h, l, lat);
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; a = 32'd1; b = 32'd0;
      @(posedge clk); #1 a = 32'd2;
      @(posedge clk); #1 in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || sat_count !== 4'd1) begin n_fail++; $display("FAIL rst_preload: got v=%b cnt=%0d want 1 1", out_valid, sat_count); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
      n_checks++; if (sat_count !== 4'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d want 0", sat_count); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      n_del = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(posedge clk); #1;
         in_valid = (cyc == 0); a = 32'd10; b = 32'd4; out_ready = 1'b1;
         #1;
         if (out_valid & out_ready) begin
            n_del++;
            n_checks++; if (out !== 32'd6) begin n_fail++; $display("FAIL rst_after_result: got %h want 00000006", out); end
         end
      end
      in_valid = 1'b0;
      n_checks++; if (n_del !== 1) begin n_fail++; $display("FAIL rst_after_count: got %0d results want 1", n_del); end
   endtask

   task automatic test_random;
      logic [33:0] q[$];
      logic [33:0] exp_v, held_v;
      logic [31:0] x, y;
      logic acc, del, held, clr;
      int cnt_m;
      cnt_m = 0; held = 1'b0; held_v = 34'd0;
      @(posedge clk);
      for (int cyc = 0; cyc < 330; cyc++) begin
         #1;
         x = pick(); y = pick();
         in_valid  = (cyc < 300) && ($urandom_range(0, 3) != 0);
         out_ready = (cyc >= 300) || ($urandom_range(0, 3) != 0);
         clr       = (cyc == 0) || ((cyc < 300) && ($urandom_range(0, 40) == 0));
         clr_count = clr; a = x; b = y;
         #1;
         if (held) begin
            n_checks++; if ({sat_hi, sat_lo, out} !== held_v || out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_stall_hold c%0d: got %h want %h", cyc, {sat_hi, sat_lo, out}, held_v); end
         end
         if (cyc > 0) begin
            n_checks++; if (sat_count !== cnt_m[3:0]) begin n_fail++; $display("FAIL rand_count c%0d: got %0d want %0d", cyc, sat_count, cnt_m); end
         end
         acc = in_valid & in_ready;
         del = out_valid & out_ready;
         exp_v = 34'd0;
         if (del) begin
            n_checks++;
            if (q.size() == 0) begin n_fail++; $display("FAIL rand_extra c%0d: got %h want none", cyc, out); end
            else begin
               exp_v = q.pop_front();
               if ({sat_hi, sat_lo, out} !== exp_v) begin n_fail++; $display("FAIL rand_result c%0d: got %h want %h", cyc, {sat_hi, sat_lo, out}, exp_v); end
            end
         end
         if (clr) cnt_m = 0;
         else if (del && (exp_v[33] | exp_v[32]) && cnt_m < 15) cnt_m++;
         if (acc) q.push_back(ref_sub(x, y));
         held = out_valid & !out_ready;
         held_v = {sat_hi, sat_lo, out};
         @(posedge clk);
      end
      #1 clr_count = 1'b0; in_valid = 1'b0;
      n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL rand_drain: got %0d pending want 0", q.size()); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_clamp();
      test_backpressure();
      test_counter();
      test_reset_midflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/capped_subtractor_pipe.md
Name: capped_subtractor_pipe

Overview:
- Two-stage pipelined, signed two's-complement saturating subtractor: out = clamp(a - b).
- Companion to the combinational saturating adder, covering the subtract direction of the same clamped-arithmetic datapath.
- Valid/ready streaming on input and output.
- Per-result overflow flags plus a saturating event counter for datapath monitoring.

Parameters:
- BITWIDTH, 32, operand and result width (signed two's complement, >= 2).
- CNT_W, 16, width of the saturation-event counter (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair a/b valid.
- in_ready  output  1  block accepts a/b this cycle.
- a  input  BITWIDTH  minuend, signed.
- b  input  BITWIDTH  subtrahend, signed.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out  output  BITWIDTH  clamped difference, signed.
- sat_hi  output  1  result clamped to max positive; qualified by out_valid.
- sat_lo  output  1  result clamped to min negative; qualified by out_valid.
- sat_count  output  CNT_W  count of delivered saturated results.
- clr_count  input  1  synchronous clear of sat_count.

Behaviour:
- Reset (rst_n low, async): s1_valid=0, s2_valid=0, out=0, sat_hi=0, sat_lo=0, sat_count=0, out_valid=0. in_ready is 1 as soon as reset deasserts.
- Stage 1 (S1):
  - Registers a and b on input handshake (in_valid & in_ready).
  - Computes diff = sext(a) - sext(b), BITWIDTH+1 bits.
- Stage 2 (S2): registers the clamped result and flags, decoded from diff[BITWIDTH:BITWIDTH-1]:
  - 01 -> out = {0, all 1s}, sat_hi=1, sat_lo=0.
  - 10 -> out = {1, all 0s}, sat_lo=1, sat_hi=0.
  - 00 or 11 -> out = diff[BITWIDTH-1:0], both flags 0.
- Flow control:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; there is no combinational path from in_valid to in_ready.
- Latency and throughput: 2 cycles from input handshake to out_valid when unstalled; one result per cycle sustained.
- Stall: while out_valid & !out_ready, out, sat_hi and sat_lo hold stable. S1 may still fill if empty, so at most 2 items are in flight. Order is preserved and nothing is dropped or duplicated.
- Bubbles: an empty S1 advancing into S2 clears s2_valid. Flags on an invalid S2 are don't-care, but the implementation drives them 0.
- sat_count:
  - Increments by 1 on each output handshake (out_valid & out_ready) with sat_hi|sat_lo.
  - Sticks at 2^CNT_W-1 and does not wrap.
  - clr_count sets it to 0 next edge. Clear wins over a simultaneous increment (result 0).
- Reset mid-operation: all in-flight items are discarded; no partial output appears after reset.

Test Plan:
- Basic (BITWIDTH=32): a=5, b=3, out_ready=1 -> out=2 two cycles after acceptance, flags 0. Then a=3, b=5 -> out=0xFFFFFFFE.
- Positive clamp: a=0x7FFFFFFF, b=0xFFFFFFFF -> out=0x7FFFFFFF, sat_hi=1, sat_count=1.
- Negative clamp: a=0x80000000, b=1 -> out=0x80000000, sat_lo=1. Edge case a=b=0x80000000 -> out=0, no flags.
- Backpressure: 6 back-to-back inputs (a=i, b=0), out_ready low 5 cycles -> in_ready drops after 2 accepted, out holds 0. On release, outputs 0..5 appear in order, one per cycle.
- Counter (CNT_W=4): 17 saturating results -> sat_count=15. Then clr_count pulsed in the same cycle as a saturating handshake -> sat_count=0.
- Reset: assert rst_n low with 2 items in flight -> out_valid=0 immediately and sat_count=0. After release, the first new input yields its own result only.
